// File: rtl/cp0_pkg.sv
// cp0_pkg: CP0 register numbers, field positions and constants shared by the CP0 block.
package cp0_pkg;
  localparam logic [4:0] sr_addr = 5'd12;
  localparam logic [4:0] cause_addr = 5'd13;
  localparam logic [4:0] epc_addr = 5'd14;
  localparam logic [4:0] prid_addr = 5'd15;
  localparam int im_lo = 10;
  localparam int exl_bit = 1;
  localparam int ie_bit = 0;
  localparam int bd_bit = 31;
  localparam int ip_lo = 10;
  localparam int exc_lo = 2;
  localparam logic [31:0] prid_value = 32'h4350_3037;
  localparam logic [31:0] handler_addr = 32'h0000_4180;
endpackage

// File: rtl/cp0_int_arbiter.sv
// cp0_int_arbiter: decides whether to take an interrupt or exception and which code to latch.
module cp0_int_arbiter (
  input  logic [5:0] hw_int,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [4:0] exc_code_in,
  output logic       req,
  output logic [4:0] code
);
  logic int_req, exc_req;
  assign int_req = |(hw_int & im) & ie & ~exl;
  assign exc_req = |exc_code_in & ~exl;
  assign req = int_req | exc_req;
  // interrupts win over a simultaneous synchronous exception
  assign code = int_req ? 5'd0 : exc_code_in;
endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: SR/Cause/EPC coprocessor-0 registers with exception entry; CP0_PRID_EN adds read-only PRId.
module cp0_regfile
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_in,
  output logic [31:0] cp0_out,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic [31:0] epc_out,
  output logic        req
);
  logic [5:0] im, ip;
  logic exl, ie, bd, arb_req;
  logic [4:0] exc_code, code;
  logic [31:0] epc, pc_al, sr, cause;
  cp0_int_arbiter u_arb (
    .hw_int(hw_int),
    .im(im),
    .ie(ie),
    .exl(exl),
    .exc_code_in(exc_code_in),
    .req(arb_req),
    .code(code)
  );
  // keep req quiet while reset is held, whatever the M-stage presents
  assign req = arb_req & rst_n;
  assign pc_al = vpc & ~32'd3;
  assign epc_out = epc;
  always_comb begin
    sr = '0;
    sr[im_lo +: 6] = im;
    sr[exl_bit] = exl;
    sr[ie_bit] = ie;
    cause = '0;
    cause[bd_bit] = bd;
    cause[ip_lo +: 6] = ip;
    cause[exc_lo +: 5] = exc_code;
  end
  always_comb begin
    cp0_out = cp0_addr == sr_addr ? sr :
              cp0_addr == cause_addr ? cause :
              cp0_addr == epc_addr ? epc :
`ifdef CP0_PRID_EN
              cp0_addr == prid_addr ? prid_value :
`endif
              32'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im <= '0;
      ie <= 1'b0;
      exl <= 1'b0;
      bd <= 1'b0;
      ip <= '0;
      exc_code <= '0;
      epc <= '0;
    end else begin
      ip <= hw_int;
      if (req) begin
        exl <= 1'b1;
        bd <= bd_in;
        exc_code <= code;
        epc <= bd_in ? pc_al - 32'd4 : pc_al;
      end else begin
        if (exl_clr) exl <= 1'b0;
        if (en && cp0_addr == sr_addr) begin
          im <= cp0_in[im_lo +: 6];
          exl <= cp0_in[exl_bit];
          ie <= cp0_in[ie_bit];
        end
        if (en && cp0_addr == epc_addr) epc <= cp0_in;
      end
    end
  end
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed scoreboard bench for cp0_regfile; honours CP0_PRID_EN.
module tb_cp0_regfile;
  logic clk = 1'b0;
  logic rst_n, en, bd_in, exl_clr, req;
  logic [4:0] cp0_addr, exc_code_in;
  logic [5:0] hw_int;
  logic [31:0] cp0_in, cp0_out, vpc, epc_out;
  int n_vec = 0;
  int n_miss = 0;
  string tag_q[$];
  logic [31:0] exp_q[$];

  cp0_regfile dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cp0_addr(cp0_addr), .cp0_in(cp0_in),
    .cp0_out(cp0_out), .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in),
    .hw_int(hw_int), .exl_clr(exl_clr), .epc_out(epc_out), .req(req)
  );

  always #5 clk = ~clk;

  task automatic push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    string t;
    logic [31:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_miss++;
      $error("FAIL scoreboard_empty: got %h want nothing", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_miss++;
        $error("FAIL %s: got %h want %h", t, obs, e);
      end
    end
  endtask

  task automatic rd(input logic [4:0] a);
    cp0_addr = a;
    #1;
    pop_cmp(cp0_out);
  endtask

  task automatic chk_req;
    #1;
    pop_cmp({31'd0, req});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; bd_in = 1'b0; exl_clr = 1'b0; cp0_addr = '0;
    cp0_in = '0; vpc = '0; hw_int = 6'h3F; exc_code_in = 5'd4;
    #2;
    push("rst_req", 32'd0); chk_req();
    push("rst_sr", 32'd0); rd(5'd12);
    push("rst_cause", 32'd0); rd(5'd13);
    push("rst_epc", 32'd0); rd(5'd14);
    push("rst_epc_out", 32'd0); pop_cmp(epc_out);
    hw_int = '0; exc_code_in = '0;
    #10 rst_n = 1'b1;
    tick();
    en = 1'b1; cp0_addr = 5'd12; cp0_in = 32'h0000_0401;
    tick();
    en = 1'b0;
    push("sr_write", 32'h0000_0401); rd(5'd12);
    hw_int = 6'd1; exc_code_in = 5'd5; vpc = 32'h0000_1000;
    push("int_req", 32'd1); chk_req();
    tick();
    exc_code_in = '0;
    push("int_cause", 32'h0000_0400); rd(5'd13);
    push("int_sr_exl", 32'h0000_0403); rd(5'd12);
    push("int_epc", 32'h0000_1000); rd(5'd14);
    push("int_epc_out", 32'h0000_1000); pop_cmp(epc_out);
    exc_code_in = 5'd10; hw_int = 6'h3F; vpc = 32'h0000_7770;
    push("exl_mask_req", 32'd0); chk_req();
    tick();
    push("exl_epc_hold", 32'h0000_1000); pop_cmp(epc_out);
    push("exl_ip", 32'h0000_FC00); rd(5'd13);
    exc_code_in = '0; hw_int = 6'd1; exl_clr = 1'b1; vpc = 32'h0000_2000;
    push("eret_pre_req", 32'd0); chk_req();
    tick();
    exl_clr = 1'b0;
    push("eret_sr", 32'h0000_0401); rd(5'd12);
    push("eret_pending_req", 32'd1); chk_req();
    tick();
    push("int2_epc", 32'h0000_2000); pop_cmp(epc_out);
    hw_int = '0; exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    exc_code_in = 5'd4; vpc = 32'h0000_3008; bd_in = 1'b1;
    push("exc_req", 32'd1); chk_req();
    tick();
    exc_code_in = '0; bd_in = 1'b0;
    push("bd_cause", 32'h8000_0010); rd(5'd13);
    push("bd_epc", 32'h0000_3004); pop_cmp(epc_out);
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    en = 1'b1; cp0_addr = 5'd14; cp0_in = 32'h0000_5000; exc_code_in = 5'd8; vpc = 32'h0000_400C;
    push("race_req", 32'd1); chk_req();
    tick();
    en = 1'b0; exc_code_in = '0;
    push("race_epc", 32'h0000_400C); pop_cmp(epc_out);
    push("race_cause", 32'h0000_0020); rd(5'd13);
    exl_clr = 1'b1;
    tick();
    exl_clr = 1'b0;
    en = 1'b1; cp0_addr = 5'd13; cp0_in = 32'hFFFF_FFFF;
    tick();
    push("cause_ro", 32'h0000_0020); rd(5'd13);
    en = 1'b1; cp0_addr = 5'd12; cp0_in = 32'hFFFF_FFFC;
    tick();
    en = 1'b0;
    push("sr_mask", 32'h0000_FC00); rd(5'd12);
    en = 1'b1; cp0_addr = 5'd14; cp0_in = 32'h1234_5678;
    #1;
    push("epc_no_bypass", 32'h0000_400C); pop_cmp(epc_out);
    tick();
    en = 1'b0;
    push("epc_write", 32'h1234_5678); pop_cmp(epc_out);
    push("unimpl_rd", 32'd0); rd(5'd3);
`ifdef CP0_PRID_EN
    push("prid_rd", 32'h4350_3037);
`else
    push("prid_rd", 32'd0);
`endif
    rd(5'd15);
    en = 1'b1; cp0_addr = 5'd15; cp0_in = 32'h0;
    tick();
    en = 1'b0;
`ifdef CP0_PRID_EN
    push("prid_ro", 32'h4350_3037);
`else
    push("prid_ro", 32'd0);
`endif
    rd(5'd15);
    exc_code_in = 5'd12; vpc = 32'h0000_5550;
    tick();
    push("handler_epc", 32'h0000_5550); pop_cmp(epc_out);
    #2 rst_n = 1'b0;
    push("midrst_req", 32'd0); chk_req();
    push("midrst_epc_out", 32'd0); pop_cmp(epc_out);
    push("midrst_sr", 32'd0); rd(5'd12);
    push("midrst_cause", 32'd0); rd(5'd13);
    exc_code_in = '0;
    #1 rst_n = 1'b1;
    tick();
    push("resume_sr", 32'd0); rd(5'd12);
    push("resume_req", 32'd0); chk_req();
    if (exp_q.size() != 0) begin
      n_miss++;
      $error("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
